// File: rtl/reduction_tree.sv
`default_nettype none
// ============================================================================
//  Module      : reduction_tree
//  Description : Sums NUM_COLS columns of MAT_HEIGHT FP16 elements into one
//                FP16 result. Each column is reduced by a combinational
//                pairwise adder tree. Column sums are then accumulated in
//                strict column order through a two-stage pipeline with a
//                valid/ready result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module reduction_tree #(
    parameter int DATA_WIDTH = 16,  // must be 16 (binary16 elements)
    parameter int MAT_HEIGHT = 4,   // power of two, >= 2
    parameter int NUM_COLS   = 4    // >= 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] column [MAT_HEIGHT],
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  busy
);

    localparam int C_LEVELS = $clog2(MAT_HEIGHT);
    localparam int C_CNT_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_COL = C_CNT_W'(NUM_COLS - 1);

    // ------------------------------------------------------------------------
    // IEEE-754 binary16 addition, round to nearest even, subnormals kept.
    // Any NaN input or (+Inf)+(-Inf) gives the quiet NaN 0x7E00; an exact
    // zero result is +0 unless both operands are negative.
    // Alignment keeps guard, round and sticky bits below the 11-bit
    // significand so one post-subtraction left shift still rounds exactly.
    // ------------------------------------------------------------------------
    function automatic logic [15:0] addfp16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, res;
        logic [4:0]  ex, ey, ex_eff, ey_eff, ex_m1, d, lz, sh;
        logic [27:0] y_sh;
        logic [13:0] ax, ay, n;
        logic [14:0] s, mag;
        logic [5:0]  e;
        logic [4:0]  ef;
        logic        found, rnd, a_nan, b_nan, a_inf, b_inf;

        res    = 16'h0000;
        x      = a;
        y      = b;
        y_sh   = '0;
        ay     = '0;
        n      = '0;
        e      = '0;
        lz     = '0;
        sh     = '0;
        found  = 1'b0;
        a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
        a_inf  = (a[14:0] == 15'h7c00);
        b_inf  = (b[14:0] == 15'h7c00);

        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
            res = 16'h7e00;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else begin
            // x always carries the larger magnitude, so the difference is >= 0
            if (a[14:0] < b[14:0]) begin
                x = b;
                y = a;
            end
            ex     = x[14:10];
            ey     = y[14:10];
            ex_eff = (ex == 5'd0) ? 5'd1 : ex;
            ey_eff = (ey == 5'd0) ? 5'd1 : ey;
            ax     = {(ex != 5'd0), x[9:0], 3'b000};
            d      = ex_eff - ey_eff;
            if (d >= 5'd14) begin
                ay = {13'd0, ((ey != 5'd0) || (y[9:0] != 10'd0))};
            end else begin
                y_sh = {(ey != 5'd0), y[9:0], 17'd0} >> d;
                ay   = {y_sh[27:15], (y_sh[14] || (y_sh[13:0] != 14'd0))};
            end

            if (x[15] == y[15]) begin
                s = {1'b0, ax} + {1'b0, ay};
            end else begin
                s = {1'b0, ax} - {1'b0, ay};
            end

            if (s == 15'd0) begin
                res = {(x[15] & y[15]), 15'd0};
            end else begin
                if (s[14]) begin
                    // carry out: shift right once, folding the lost bit into sticky
                    n = {s[14:2], (s[1] | s[0])};
                    e = {1'b0, ex_eff} + 6'd1;
                end else begin
                    for (int i = 13; i >= 0; i--) begin
                        if (!found) begin
                            if (s[i]) begin
                                found = 1'b1;
                            end else begin
                                lz = lz + 5'd1;
                            end
                        end
                    end
                    // never normalise below the minimum exponent: that is a subnormal
                    ex_m1 = ex_eff - 5'd1;
                    sh    = (lz > ex_m1) ? ex_m1 : lz;
                    n     = s[13:0] << sh;
                    e     = {1'b0, ex_eff} - {1'b0, sh};
                end

                if (e >= 6'd31) begin
                    res = {x[15], 15'h7c00};
                end else begin
                    ef  = n[13] ? e[4:0] : 5'd0;
                    rnd = n[2] & (n[1] | n[0] | n[3]);
                    // rounding carry ripples into the exponent field (and to Inf)
                    mag = {ef, n[12:3]} + {14'd0, rnd};
                    res = {x[15], mag};
                end
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Column adder tree: level l holds MAT_HEIGHT>>l partial sums, each the
    // sum of an adjacent pair from the level below, in index order.
    // ------------------------------------------------------------------------
    for (genvar l = 0; l <= C_LEVELS; l++) begin : g_level
        logic [DATA_WIDTH-1:0] w_lvl [MAT_HEIGHT >> l];
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < MAT_HEIGHT; j++) begin : g_in
                assign w_lvl[j] = column[j];
            end
        end else begin : g_add
            for (genvar j = 0; j < (MAT_HEIGHT >> l); j++) begin : g_pair
                assign w_lvl[j] = addfp16(g_level[l-1].w_lvl[2*j], g_level[l-1].w_lvl[2*j+1]);
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_col_sum;
    assign w_col_sum = g_level[C_LEVELS].w_lvl[0];

    // ------------------------------------------------------------------------
    // Pipeline state and handshake
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_s1_sum;
    logic                  r_s1_valid;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic [C_CNT_W-1:0]    r_col_cnt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_valid_out;

    logic                  w_stall;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_next;

    // A finished group cannot leave stage 1 while the previous result is unread
    assign w_stall   = r_valid_out && !ready_out && r_s1_valid && r_s1_last;
    assign ready_in  = !w_stall && !clear;
    assign w_accept  = valid_in && ready_in;
    assign w_advance = r_s1_valid && !w_stall && !clear;
    assign w_load    = w_advance && r_s1_last;
    assign w_next    = r_s1_first ? r_s1_sum : addfp16(r_acc, r_s1_sum);
    assign busy      = r_s1_valid || (r_col_cnt != '0);
    assign valid_out = r_valid_out;
    assign sum       = r_sum;

    // Stage 1: capture the column sum with its group position, count columns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_sum   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_col_cnt  <= '0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
            r_col_cnt  <= '0;
        end else if (w_accept) begin
            r_s1_sum   <= w_col_sum;
            r_s1_valid <= 1'b1;
            r_s1_first <= (r_col_cnt == '0);
            r_s1_last  <= (r_col_cnt == C_LAST_COL);
            r_col_cnt  <= (r_col_cnt == C_LAST_COL) ? '0 : r_col_cnt + 1'b1;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: running accumulator for the columns before the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (w_advance && !r_s1_last) begin
            r_acc <= w_next;
        end
    end

    // Result register: a new result wins over the handshake on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_valid_out <= 1'b0;
        end else if (w_load) begin
            r_sum       <= w_next;
            r_valid_out <= 1'b1;
        end else if (ready_out) begin
            r_valid_out <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reduction_tree.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reduction_tree
//  Description : Self-checking bench for reduction_tree. Directed group
//                scenarios on three configurations plus a long randomized run
//                against a real-arithmetic FP16 reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reduction_tree;

    localparam int C_RND_GROUPS = 10000;
    localparam int C_RND_BEATS  = C_RND_GROUPS * 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // configuration A: H=2, N=2
    logic        clear_a, vin_a, rdy_in_a, vout_a, rout_a, busy_a;
    logic [15:0] col_a [2];
    logic [15:0] sum_a;
    // configuration B: H=4, N=3
    logic        clear_b, vin_b, rdy_in_b, vout_b, rout_b, busy_b;
    logic [15:0] col_b [4];
    logic [15:0] sum_b;
    // configuration C: H=2, N=1
    logic        clear_c, vin_c, rdy_in_c, vout_c, rout_c, busy_c;
    logic [15:0] col_c [2];
    logic [15:0] sum_c;

    reduction_tree #(.DATA_WIDTH(16), .MAT_HEIGHT(2), .NUM_COLS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a), .valid_in(vin_a), .ready_in(rdy_in_a),
        .column(col_a), .valid_out(vout_a), .ready_out(rout_a), .sum(sum_a), .busy(busy_a));

    reduction_tree #(.DATA_WIDTH(16), .MAT_HEIGHT(4), .NUM_COLS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b), .valid_in(vin_b), .ready_in(rdy_in_b),
        .column(col_b), .valid_out(vout_b), .ready_out(rout_b), .sum(sum_b), .busy(busy_b));

    reduction_tree #(.DATA_WIDTH(16), .MAT_HEIGHT(2), .NUM_COLS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear_c), .valid_in(vin_c), .ready_in(rdy_in_c),
        .column(col_c), .valid_out(vout_c), .ready_out(rout_c), .sum(sum_c), .busy(busy_c));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- FP16 reference via real arithmetic --------------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        if (h[14:10] == 5'd0) m = real'(h[9:0]) * pow2(-24);
        else                  m = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -m : m;
    endfunction

    function automatic int rne(input real x);
        int  q = $rtoi(x);
        real fr = x - real'(q);
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
        return q;
    endfunction

    function automatic logic [15:0] r2h(input real v, input logic zsign);
        logic s;
        real  m;
        int   e, q;
        if (v == 0.0) return {zsign, 15'd0};
        s = (v < 0.0);
        m = s ? -v : v;
        if (m < pow2(-14)) begin
            q = rne(m * pow2(24));
            return {s, 15'(q)};
        end
        e = -14;
        while (e < 16 && m >= pow2(e + 1)) e++;
        q = rne(m * pow2(10 - e));
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e > 15) return {s, 15'h7c00};
        return {s, 5'(e + 15), 10'(q - 1024)};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b), a[15] & b[15]);
    endfunction

    // pairwise halving in index order
    function automatic logic [15:0] col_sum4(input logic [15:0] c [4]);
        logic [15:0] v [4];
        int n = 4;
        for (int i = 0; i < 4; i++) v[i] = c[i];
        while (n > 1) begin
            for (int j = 0; j < n / 2; j++) v[j] = fadd(v[2*j], v[2*j+1]);
            n = n / 2;
        end
        return v[0];
    endfunction

    function automatic logic [15:0] rnd_h();
        logic [15:0] h;
        h = {1'($urandom_range(1, 0)), 5'($urandom_range(18, 0)), 10'($urandom)};
        return h;
    endfunction

    // ---------------- scoreboard for the randomized run on B ----------------
    bit          rnd_on = 1'b0;
    logic [15:0] exp_q [$];
    logic [15:0] acc_ref;
    logic [15:0] cs_tmp;
    int          col_idx   = 0;
    int          beats_b   = 0;
    int          results_b = 0;
    int          hs_c      = 0;

    always @(negedge clk) begin
        if (rnd_on) begin
            if (vin_b && rdy_in_b && !clear_b) begin
                cs_tmp  = col_sum4(col_b);
                acc_ref = (col_idx == 0) ? cs_tmp : fadd(acc_ref, cs_tmp);
                col_idx++;
                beats_b++;
                if (col_idx == 3) begin
                    exp_q.push_back(acc_ref);
                    col_idx = 0;
                end
            end
            if (vout_b && rout_b) begin
                results_b++;
                if (exp_q.size() == 0) check("rnd_extra_result", results_b, beats_b / 3);
                else                   check("rnd_sum", sum_b, exp_q.pop_front());
            end
        end
        if (vout_c && rout_c) hs_c++;
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        rst_n = 1'b0;
        clear_a = 0; vin_a = 0; rout_a = 1; col_a[0] = 0; col_a[1] = 0;
        clear_b = 0; vin_b = 0; rout_b = 1; for (int i = 0; i < 4; i++) col_b[i] = 0;
        clear_c = 0; vin_c = 0; rout_c = 0; col_c[0] = 0; col_c[1] = 0;

        #12;
        check("rst_vout_a", vout_a, 0);
        check("rst_sum_a", sum_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_rdy_a", rdy_in_a, 1);
        check("rst_busy_b", busy_b, 0);
        check("rst_vout_c", vout_c, 0);
        @(posedge clk) #1 rst_n = 1'b1;

        // two columns back to back -> 10.0, one-cycle valid, latency k+1
        vin_a = 1; col_a[0] = 16'h3C00; col_a[1] = 16'h4000;
        @(posedge clk) #1 col_a[0] = 16'h4200; col_a[1] = 16'h4400;
        @(posedge clk) #1 vin_a = 0;
        check("t030_not_early", vout_a, 0);
        check("t030_busy", busy_a, 1);
        @(posedge clk) #1;
        check("t030_vout", vout_a, 1);
        check("t030_sum", sum_a, 16'h4900);
        @(posedge clk) #1;
        check("t030_one_cycle", vout_a, 0);

        // three columns of ones, H=4 -> 12.0, busy span
        vin_b = 1; for (int i = 0; i < 4; i++) col_b[i] = 16'h3C00;
        @(posedge clk) #1 check("t031_busy1", busy_b, 1);
        @(posedge clk) #1 check("t031_busy2", busy_b, 1);
        @(posedge clk) #1 vin_b = 0;
        check("t031_busy3", busy_b, 1);
        check("t031_not_early", vout_b, 0);
        @(posedge clk) #1;
        check("t031_vout", vout_b, 1);
        check("t031_sum", sum_b, 16'h4A00);
        check("t031_idle", busy_b, 0);

        // N=1 back-pressure: result held, input stalls, nothing lost
        vin_c = 1; col_c[0] = 16'h3C00; col_c[1] = 16'h3C00;
        @(posedge clk) #1;
        @(posedge clk) #1;
        check("t032_vout", vout_c, 1);
        check("t032_sum", sum_c, 16'h4000);
        check("t032_stall", rdy_in_c, 0);
        @(posedge clk) #1;
        check("t032_stall_hold", rdy_in_c, 0);
        check("t032_vout_hold", vout_c, 1);
        rout_c = 1; vin_c = 0;
        #1 check("t032_unstall", rdy_in_c, 1);
        @(posedge clk) #1;
        check("t032_second_vout", vout_c, 1);
        check("t032_second_sum", sum_c, 16'h4000);
        @(posedge clk) #1;
        check("t032_drained", vout_c, 0);
        check("t032_handshakes", hs_c, 2);

        // clear aborts a partial group; beat shown with clear is dropped
        vin_a = 1; col_a[0] = 16'h4400; col_a[1] = 16'h4400;
        @(posedge clk) #1 clear_a = 1;
        #1 check("t033_rdy_clear", rdy_in_a, 0);
        @(posedge clk) #1 clear_a = 0;
        check("t033_busy_cleared", busy_a, 0);
        col_a[0] = 16'h3C00; col_a[1] = 16'h3C00;
        @(posedge clk) #1;
        @(posedge clk) #1 vin_a = 0;
        check("t033_no_aborted", vout_a, 0);
        @(posedge clk) #1;
        check("t033_vout", vout_a, 1);
        check("t033_sum", sum_a, 16'h4400);

        // asynchronous reset with a held result and a partial group in flight
        @(posedge clk) #1 rout_a = 0; vin_a = 1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        @(posedge clk) #1 vin_a = 0;
        check("t034_pre_vout", vout_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t034_vout", vout_a, 0);
        check("t034_sum", sum_a, 0);
        check("t034_busy", busy_a, 0);
        @(posedge clk) #1 rst_n = 1'b1; rout_a = 1;
        vin_a = 1; col_a[0] = 16'h3C00; col_a[1] = 16'h4000;
        @(posedge clk) #1 col_a[0] = 16'h4200; col_a[1] = 16'h4400;
        @(posedge clk) #1 vin_a = 0;
        @(posedge clk) #1;
        check("t034_after_vout", vout_a, 1);
        check("t034_after_sum", sum_a, 16'h4900);

        // randomized traffic on B against the reference model
        repeat (3) @(posedge clk);
        #1 rnd_on = 1'b1;
        cyc = 0;
        while (beats_b < C_RND_BEATS && cyc < 90000) begin
            vin_b  = ($urandom_range(7, 0) != 0);
            rout_b = ($urandom_range(3, 0) != 0);
            for (int i = 0; i < 4; i++) col_b[i] = rnd_h();
            @(posedge clk) #1;
            cyc++;
        end
        vin_b  = 0;
        rout_b = 1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || vout_b); i++) @(posedge clk) #1;
        check("rnd_beats", beats_b, C_RND_BEATS);
        check("rnd_pending", exp_q.size(), 0);
        check("rnd_results", results_b, C_RND_GROUPS);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reduction_tree.md
REDUCTION_TREE -- requirements
Module: reduction_tree

Interface
REQ-001 Parameter DATA_WIDTH, default 16, element width; only 16 is legal (FP16 via addfp16).
REQ-002 Parameter MAT_HEIGHT, default 4, elements per column; power of two, >= 2.
REQ-003 Parameter NUM_COLS, default 4, columns per reduction group; >= 1.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous abort of the partial group.
REQ-007 valid_in  input  1  column beat valid.
REQ-008 ready_in  output  1  block can accept a beat this cycle.
REQ-009 column  input  DATA_WIDTH x MAT_HEIGHT  unpacked array, FP16 elements, index 0..MAT_HEIGHT-1.
REQ-010 valid_out  output  1  sum holds a completed group result.
REQ-011 ready_out  input  1  downstream accepts the result.
REQ-012 sum  output  DATA_WIDTH  FP16 sum of all MAT_HEIGHT*NUM_COLS elements of one group.
REQ-013 busy  output  1  high while any beat of an incomplete group is held or counted.

Function
REQ-014 Beat accepted on a rising edge where valid_in && ready_in && !clear.
REQ-015 Column sum: combinational pairwise addfp16 tree, level 0 adds column[2i]+column[2i+1], each further level adds adjacent results in index order; log2(MAT_HEIGHT) levels.
REQ-016 Stage 1 register (s1_sum, s1_valid, s1_first, s1_last) captures the column sum on acceptance; first/last from column counter col_cnt (0..NUM_COLS-1).
REQ-017 col_cnt increments per accepted beat, wraps to 0 after NUM_COLS-1; first = (col_cnt==0), last = (col_cnt==NUM_COLS-1); NUM_COLS=1 gives first and last on every beat.
REQ-018 Stage 2: when s1_valid advances, next = s1_first ? s1_sum : addfp16(acc, s1_sum); if !s1_last acc <= next; if s1_last sum <= next and valid_out <= 1.
REQ-019 Accumulation order fixed: ((col0+col1)+col2)+...; no reordering, bit-exact to this order.
REQ-020 valid_out, sum held stable until a rising edge with ready_out high; then valid_out <= 0 unless a new result loads on the same edge (new result wins, valid_out stays 1).
REQ-021 stall = valid_out && !ready_out && s1_valid && s1_last; during stall s1, acc and col_cnt hold.
REQ-022 ready_in = !stall && !clear; otherwise high, including while valid_out is held with no pending last beat.
REQ-023 s1_valid clears on an advancing edge with no new acceptance; s1 reloads on an edge with both.
REQ-024 Latency: last beat accepted at edge k -> valid_out high after edge k+1 when not stalled; throughput one column per cycle.
REQ-025 clear: next edge sets col_cnt=0, s1_valid=0, acc=0; valid_out/sum untouched; beat presented with clear is dropped.
REQ-026 busy = s1_valid || (col_cnt != 0).
REQ-027 No NaN/Inf special handling beyond addfp16 behaviour.

Reset
REQ-028 rst_n low asynchronously forces valid_out=0, sum=0, acc=0, s1_valid=0, s1_sum=0, col_cnt=0, busy=0; ready_in=1 once clear is low.
REQ-029 Reset mid-group discards all partial state; first beat after release is column 0 of a new group.

Verification
REQ-030 H=2,N=2, ready_out=1: columns {0x3C00,0x4000},{0x4200,0x4400} back-to-back -> sum=0x4900 (10.0), valid_out one cycle, after edge k+1 of last beat.
REQ-031 H=4,N=3: three columns all 0x3C00 -> sum=0x4A00 (12.0); busy high from first acceptance until result load.
REQ-032 H=2,N=1, ready_out=0: continuous beats {0x3C00,0x3C00} -> first sum=0x4000 held, ready_in drops after second beat enters s1; raise ready_out -> second 0x4000 loads same edge, no beat lost or duplicated.
REQ-033 H=2,N=2: one column {0x4400,0x4400}, assert clear, then {0x3C00,0x3C00},{0x3C00,0x3C00} -> sum=0x4400 (4.0), aborted 8.0 absent.
REQ-034 Drive rst_n low mid-group with valid_out=1 -> all outputs zero immediately; next full group gives correct sum.
REQ-035 Random valid_in/ready_out over 10k groups vs. ordered reference model -> bit-exact sums, in order, none dropped.
